fcc_mem_rd_arb: RTL and testbench

Parametrised multi-channel read arbiter and line sequencer for the FC accelerator.
- Serves NUM_CH independent byte-range read requestors (e.g. pic, wgt, bias) on one shared line-based memory read port.
- Splits each request into LINE_BYTES line reads and routes the returned lines back to the owning channel, with last / last_valid framing.
- Supersedes the fixed, single-line-per-channel response path: adds arbitration, multi-line bursts and an outstanding-read limit.

---
 rtl/fcc_mem_pkg.sv | 23 ++
 rtl/fcc_rr_arb.sv | 27 ++
 rtl/fcc_mem_rd_arb.sv | 204 ++++++++++++++++++++
 tb/tb_fcc_mem_rd_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcc_mem_pkg.sv
// Shared types and helpers for the FC accelerator memory read path.
// Line geometry default, sequencer state encoding and line-count arithmetic.
package fcc_mem_pkg;

  localparam int unsigned LINE_BYTES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [LINE_BYTES_DEF-1:0][7:0] line_t;

  // Number of lines covering a request; a zero-byte request still reads one line.
  function automatic logic [31:0] ceil_lines(input logic [31:0] size_bytes,
                                             input int unsigned lb_w);
    logic [31:0] s;
    s = (size_bytes == 32'd0) ? 32'd1 : size_bytes;
    return ((s - 32'd1) >> lb_w) + 32'd1;
  endfunction

endpackage

// File: rtl/fcc_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// One-hot grant, all-zero when no request is present.
module fcc_rr_arb #(
  parameter int NUM_CH = 3,
  parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcc_mem_rd_arb.sv
// Multi-channel byte-range reader: arbitrates channels, splits requests into line reads,
// returns lines to the owner one cycle after mem_rd_valid; issue stalls at MAX_OUTSTANDING.
module fcc_mem_rd_arb
  import fcc_mem_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int ADDR_WIDTH      = 19,
  parameter int LINE_BYTES      = LINE_BYTES_DEF,
  parameter int MAX_BYTES_TO_RD = 16384,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SZ_W            = $clog2(MAX_BYTES_TO_RD + 1),
  parameter int LB_W            = $clog2(LINE_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_start_addr,
  input  logic [NUM_CH*SZ_W-1:0]     ch_size_bytes,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_last,
  output logic [LINE_BYTES*8-1:0]    ch_data,
  output logic [LB_W-1:0]            ch_last_valid,
  output logic                       mem_rd_req,
  output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic                       mem_rd_gnt,
  input  logic                       mem_rd_valid,
  input  logic [LINE_BYTES*8-1:0]    mem_rd_data,
  output logic                       busy,
  output logic                       err_unexp
);

  localparam int CNT_W = $clog2(MAX_BYTES_TO_RD / LINE_BYTES + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        to_issue_q, to_issue_d;
  logic [CNT_W-1:0]        returned_q, returned_d;
  logic [CNT_W-1:0]        n_lines_q, n_lines_d;
  logic [LB_W-1:0]         lv_q, lv_d;
  logic [OUT_W-1:0]        outst_q, outst_d;
  logic                    err_q, err_d;
  logic [NUM_CH-1:0]       vld_q, vld_d;
  logic [NUM_CH-1:0]       last_q, last_d;
  logic [LINE_BYTES*8-1:0] data_q, data_d;
  logic [LB_W-1:0]         last_lv_q, last_lv_d;

  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     gnt_oh;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SZ_W-1:0]       sel_size;
  logic [SZ_W-1:0]       size_eff;
  logic                  rd_fire;
  logic                  ret_ok;
  logic                  ret_last;

  // The owner that just finished is masked for one cycle while it drops ch_req.
  assign eligible = ch_req & ~mask_q;

  fcc_rr_arb #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_arb (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (gnt_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) win_idx = PTR_W'(i);
    end
  end

  assign sel_addr = ch_start_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_size = ch_size_bytes[win_idx*SZ_W +: SZ_W];
  assign size_eff = (sel_size == '0) ? SZ_W'(1) : sel_size;

  assign rd_fire  = mem_rd_req & mem_rd_gnt;
  assign ret_ok   = mem_rd_valid && (state_q != IDLE) && (outst_q != '0);
  assign ret_last = ret_ok && ((returned_q + CNT_W'(1)) == n_lines_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|eligible) state_d = ISSUE;
      ISSUE:   if (rd_fire && (to_issue_q == CNT_W'(1))) state_d = DRAIN;
      DRAIN:   if (ret_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_rd_req  = (state_q == ISSUE) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    mem_rd_addr = (state_q == ISSUE) ? addr_q : '0;
    busy        = (state_q != IDLE);
  end

  always_comb begin
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    mask_d     = '0;
    addr_d     = addr_q;
    to_issue_d = to_issue_q;
    returned_d = returned_q;
    n_lines_d  = n_lines_q;
    lv_d       = lv_q;
    outst_d    = outst_q;
    err_d      = err_q;
    vld_d      = '0;
    last_d     = '0;
    data_d     = data_q;
    last_lv_d  = '0;

    if ((state_q == IDLE) && (|eligible)) begin
      owner_d    = win_idx;
      addr_d     = sel_addr;
      n_lines_d  = CNT_W'(ceil_lines(32'(size_eff), LB_W));
      to_issue_d = CNT_W'(ceil_lines(32'(size_eff), LB_W));
      returned_d = '0;
      lv_d       = LB_W'(size_eff - SZ_W'(1));
    end

    if (rd_fire) begin
      addr_d     = addr_q + ADDR_WIDTH'(LINE_BYTES);
      to_issue_d = to_issue_q - CNT_W'(1);
    end

    unique case ({rd_fire, ret_ok})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (ret_ok) begin
      returned_d       = returned_q + CNT_W'(1);
      data_d           = mem_rd_data;
      vld_d[owner_q]   = 1'b1;
      if (ret_last) begin
        last_d[owner_q] = 1'b1;
        last_lv_d       = lv_q;
        mask_d[owner_q] = 1'b1;
        rr_ptr_d        = (owner_q == PTR_W'(NUM_CH - 1)) ? '0 : owner_q + PTR_W'(1);
      end
    end

    if (mem_rd_valid && !ret_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      to_issue_q <= '0;
      returned_q <= '0;
      n_lines_q  <= '0;
      lv_q       <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      last_q     <= '0;
      data_q     <= '0;
      last_lv_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      to_issue_q <= to_issue_d;
      returned_q <= returned_d;
      n_lines_q  <= n_lines_d;
      lv_q       <= lv_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      data_q     <= data_d;
      last_lv_q  <= last_lv_d;
    end
  end

  assign ch_valid      = vld_q;
  assign ch_last       = last_q;
  assign ch_data       = data_q;
  assign ch_last_valid = last_lv_q;
  assign err_unexp     = err_q;

endmodule

// File: tb/tb_fcc_mem_rd_arb.sv
// Scoreboard bench for fcc_mem_rd_arb: transaction-level model predicts line addresses
// and returned beats; a negedge monitor compares what the DUT presents.
module tb_fcc_mem_rd_arb;
  import fcc_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        ch_req;
  logic [2:0][18:0]  ch_addr;
  logic [2:0][14:0]  ch_size;
  logic [2:0]        ch_valid, ch_last;
  line_t             ch_data;
  logic [4:0]        ch_lv;
  logic              mem_rd_req;
  logic [18:0]       mem_rd_addr;
  logic              mem_rd_gnt, mem_rd_valid;
  line_t             mem_rd_data;
  logic              busy, err_unexp;

  fcc_mem_rd_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_req        (ch_req),
    .ch_start_addr (ch_addr),
    .ch_size_bytes (ch_size),
    .ch_valid      (ch_valid),
    .ch_last       (ch_last),
    .ch_data       (ch_data),
    .ch_last_valid (ch_lv),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_gnt    (mem_rd_gnt),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .busy          (busy),
    .err_unexp     (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          last;
    int          lv;
    logic [255:0] data;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_addr[$];
  int    pend_addr[$];
  int    checks = 0;
  int    errors = 0;
  int    last_cnt[3];
  int    seen_cnt[3];
  int    beat_cnt = 0;
  int    grant_cnt = 0;
  int    gnt_mode = 0;
  int    vld_mode = 0;
  bit    stray = 1'b0;
  int    rr_model = 0;

  function automatic logic [255:0] pat(input int a);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'((a >>> 5) + i * 7 + (a >>> 13) * 3);
    return d;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: grants are checked against predicted addresses; beats against predicted lines.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_req && mem_rd_gnt) begin
        grant_cnt++;
        if (exp_addr.size() == 0) fail_now("unexpected_grant");
        else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
        pend_addr.push_back(int'(mem_rd_addr));
      end
      if (ch_valid != 3'b0) begin
        beat_cnt++;
        if (exp_beats.size() == 0) fail_now("unexpected_beat");
        else begin
          beat_t b;
          b = exp_beats.pop_front();
          chk("beat_ch", ch_valid, 3'b1 << b.ch);
          chk("beat_last", ch_last, b.last ? (3'b1 << b.ch) : 3'b0);
          if (b.last) chk("last_valid", ch_lv, b.lv);
          chk("beat_data", ch_data, b.data);
        end
        for (int c = 0; c < 3; c++) if (ch_last[c] && ch_valid[c]) last_cnt[c]++;
      end else if (ch_last != 3'b0) begin
        fail_now("last_without_valid");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (last_cnt[c] != seen_cnt[c]) begin
        ch_req[c]   = 1'b0;
        seen_cnt[c] = last_cnt[c];
      end
    end
    mem_rd_gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (stray) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = '1;
      stray        = 1'b0;
    end else if (pend_addr.size() > 0 &&
                 (vld_mode == 1 || (vld_mode == 2 && $urandom_range(0, 2) != 0))) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = pat(pend_addr.pop_front());
    end else begin
      mem_rd_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    ch_req       = '0;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    exp_beats.delete();
    exp_addr.delete();
    pend_addr.delete();
    rr_model = 0;
    for (int c = 0; c < 3; c++) seen_cnt[c] = last_cnt[c];
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic issue(input int ch, input int addr, input int size);
    ch_addr[ch] = 19'(addr);
    ch_size[ch] = 15'(size);
    ch_req[ch]  = 1'b1;
  endtask

  task automatic push_txn(input int ch, input int addr, input int size);
    int s, n, lv, a;
    s  = (size == 0) ? 1 : size;
    n  = (s + 31) / 32;
    lv = (s - 1) % 32;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      a      = (addr + 32 * k) % (1 << 19);
      b.ch   = ch;
      b.last = (k == n - 1);
      b.lv   = lv;
      b.data = pat(a);
      exp_addr.push_back(a);
      exp_beats.push_back(b);
    end
  endtask

  // Fair service order: repeatedly take the first pending channel at or after the pointer.
  task automatic expect_set(input logic [2:0] set);
    logic [2:0] rem;
    rem = set;
    while (rem != 3'b0) begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (rr_model + k) % 3;
        if (!found && rem[c]) begin
          push_txn(c, int'(ch_addr[c]), int'(ch_size[c]));
          rem[c]   = 1'b0;
          rr_model = (c + 1) % 3;
          found    = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_done(input logic [2:0] set, input int budget);
    int n;
    n = 0;
    while ((ch_req & set) != 3'b0 && n < budget) begin
      step();
      n++;
    end
    if ((ch_req & set) != 3'b0) begin
      fail_now("timeout_waiting_for_last");
      ch_req = '0;
    end
    repeat (3) step();
    chk("beats_outstanding", exp_beats.size(), 0);
    chk("addrs_outstanding", exp_addr.size(), 0);
  endtask

  initial begin
    logic [2:0] set;
    int g0, b0, n;
    for (int c = 0; c < 3; c++) begin
      last_cnt[c] = 0;
      seen_cnt[c] = 0;
    end
    ch_addr = '0;
    ch_size = '0;
    rst_n   = 1'b0;
    ch_req  = '0;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    #12;
    chk("reset_outputs", {ch_valid, ch_last, ch_data, ch_lv, mem_rd_req, mem_rd_addr, busy, err_unexp}, 0);
    do_reset();

    gnt_mode = 1;
    vld_mode = 1;
    issue(0, 0, 64);  expect_set(3'b001); wait_done(3'b001, 100);
    issue(0, 0, 40);  expect_set(3'b001); wait_done(3'b001, 100);

    do_reset();
    gnt_mode = 1;
    vld_mode = 1;
    issue(0, 32'h1000, 32); issue(1, 32'h2000, 32); issue(2, 32'h3000, 32);
    expect_set(3'b111); wait_done(3'b111, 200);
    issue(0, 32'h1100, 32); expect_set(3'b001); wait_done(3'b001, 100);
    issue(0, 32'h1200, 32); issue(1, 32'h2200, 32);
    expect_set(3'b011); wait_done(3'b011, 200);

    gnt_mode = 1;
    vld_mode = 0;
    issue(0, 32'h400, 256);
    expect_set(3'b001);
    g0 = grant_cnt;
    repeat (12) step();
    chk("outstanding_grants", grant_cnt - g0, 4);
    @(negedge clk);
    chk("req_stalled_at_limit", mem_rd_req, 1'b0);
    vld_mode = 1;
    wait_done(3'b001, 200);

    issue(1, 32'h7FFE0, 64); expect_set(3'b010); wait_done(3'b010, 100);
    issue(2, 32'h123, 0);    expect_set(3'b100); wait_done(3'b100, 100);

    for (int it = 0; it < 40; it++) begin
      gnt_mode = $urandom_range(1, 2);
      vld_mode = $urandom_range(1, 2);
      set = 3'($urandom_range(1, 7));
      for (int c = 0; c < 3; c++) begin
        if (set[c]) issue(c, int'($urandom_range(0, 32'h7FFFF)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1000))
                                                      : int'($urandom_range(0, 200)));
      end
      expect_set(set);
      wait_done(set, 3000);
    end
    @(negedge clk);
    chk("no_spurious_err", err_unexp, 1'b0);

    gnt_mode = 1;
    vld_mode = 1;
    issue(0, 32'h800, 128);
    expect_set(3'b001);
    b0 = beat_cnt;
    n  = 0;
    while (beat_cnt < b0 + 2 && n < 50) begin
      step();
      n++;
    end
    if (beat_cnt < b0 + 2) fail_now("timeout_waiting_for_beats");
    rst_n  = 1'b0;
    ch_req = '0;
    #1;
    chk("midreset_outputs", {ch_valid, ch_last, ch_data, ch_lv, mem_rd_req, mem_rd_addr, busy, err_unexp}, 0);
    exp_beats.delete();
    exp_addr.delete();
    pend_addr.delete();
    mem_rd_valid = 1'b0;
    gnt_mode = 0;
    vld_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    stray = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("late_return_err", err_unexp, 1'b1);
    chk("late_return_idle", {busy, ch_valid}, 0);
    do_reset();
    @(negedge clk);
    chk("err_cleared_by_reset", err_unexp, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
